// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and helpers for the mac_pipe multiply-accumulate
// block.
//   DEF_*        default parameter values for mac_pipe and mac_lane_mult
//   beat_ctl_t   per-beat control (valid + signedness) carried down the pipe
//   sum_width()  width of the lane sum, wide enough for either signedness
//   sat_limit()  clamp value for a given accumulator width and direction
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 8;

  // sat_limit() builds its result in this many bits, so ACC_W is capped here.
  localparam int LIMIT_W = 64;

  typedef struct packed {
    logic vld;
    logic sgn;
  } beat_ctl_t;

  // The sum of LANES products needs clog2(LANES) growth bits. One more bit
  // lets the same signed vector hold either a signed sum or an unsigned sum
  // (which is always non-negative).
  function automatic int sum_width(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes) + 1;
  endfunction

  // Clamp value in the low acc_w bits of the result:
  //   unsigned           -> 2^acc_w - 1
  //   signed, positive   -> 2^(acc_w-1) - 1
  //   signed, negative   -> -2^(acc_w-1)
  // An unsigned accumulation only ever adds, so it can only overflow upward.
  function automatic logic [LIMIT_W-1:0] sat_limit(input int acc_w,
                                                   input logic sgn,
                                                   input logic neg);
    logic [LIMIT_W-1:0] umax;
    logic [LIMIT_W-1:0] smax;
    umax = {LIMIT_W{1'b1}} >> (LIMIT_W - acc_w);
    smax = umax >> 1;
    if (!sgn) begin
      return umax;
    end else if (neg) begin
      return ~smax;
    end else begin
      return smax;
    end
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// mac_lane_mult: one DATA_W x DATA_W multiplier lane with a registered
// product. This register is the second pipeline stage of mac_pipe.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of the product register
//   load        capture a new product (the stage-1 beat is valid)
//   sgn         1 = operands are two's complement, 0 = unsigned
//   a, b        operands
//   p           registered 2*DATA_W product
module mac_lane_mult
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  sgn,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   p
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] prod_next;

  // Extend both operands to the product width (sign- or zero-extension by
  // sgn) and multiply modulo 2^PW. The low PW bits of a two's-complement
  // product do not depend on how the operands are interpreted, and the exact
  // result fits in PW bits for both signed and unsigned operands, so a
  // single unsigned multiplier serves both modes.
  always_comb begin
    a_x       = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    b_x       = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    prod_next = a_x * b_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (clr) begin
      p <= '0;
    end else if (load) begin
      p <= prod_next;
    end
  end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: LANES-wide multiply-accumulate with three register stages.
//   S1 registers a, b and the beat control (valid, sgn)
//   S2 registers the LANES products (in mac_lane_mult)
//   S3 sums the products, accumulates, and updates cout/cout_vld/ovf
// A beat presented with en high is captured by S1 on the next rising edge,
// and its result appears on cout/cout_vld on the third rising edge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          beat valid; a, b and sgn are sampled while high
//   clr         synchronous clear of the pipeline, accumulator, counter, ovf
//   sgn         1 = two's-complement operands, 0 = unsigned; travels with beat
//   sat_en      1 = saturate on overflow, 0 = wrap (applied in S3)
//   len         beats per vector, 0 = free-running accumulation
//   a, b        lane operands, lane 0 in the LSBs
//   cout        registered vector result, held between vectors
//   cout_vld    one-cycle pulse when cout is updated
//   ovf         sticky overflow flag
module mac_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    sgn,
  input  logic                    sat_en,
  input  logic [CNT_W-1:0]        len,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  output logic [ACC_W-1:0]        cout,
  output logic                    cout_vld,
  output logic                    ovf
);

  localparam int PW    = 2 * DATA_W;
  localparam int SUM_W = sum_width(DATA_W, LANES);

  // Clamp values, resolved at elaboration time.
  localparam logic [LIMIT_W-1:0] UMAX_FULL = sat_limit(ACC_W, 1'b0, 1'b0);
  localparam logic [LIMIT_W-1:0] SMAX_FULL = sat_limit(ACC_W, 1'b1, 1'b0);
  localparam logic [LIMIT_W-1:0] SMIN_FULL = sat_limit(ACC_W, 1'b1, 1'b1);
  localparam logic [ACC_W-1:0]   UMAX      = UMAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   SMAX      = SMAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   SMIN      = SMIN_FULL[ACC_W-1:0];

  // ---------------------------------------------------------------- S1
  logic [LANES*DATA_W-1:0] a_s1_reg;
  logic [LANES*DATA_W-1:0] b_s1_reg;
  beat_ctl_t               ctl_s1_reg;

  // Operands are only loaded on valid beats so bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_reg   <= '0;
      b_s1_reg   <= '0;
      ctl_s1_reg <= '0;
    end else if (clr) begin
      ctl_s1_reg <= '0;
    end else begin
      ctl_s1_reg.vld <= en;
      if (en) begin
        a_s1_reg       <= a;
        b_s1_reg       <= b;
        ctl_s1_reg.sgn <= sgn;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic [PW-1:0] prod_s2 [LANES];
  beat_ctl_t     ctl_s2_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane_mult #(
        .DATA_W (DATA_W)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (ctl_s1_reg.vld),
        .sgn   (ctl_s1_reg.sgn),
        .a     (a_s1_reg[gi*DATA_W +: DATA_W]),
        .b     (b_s1_reg[gi*DATA_W +: DATA_W]),
        .p     (prod_s2[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_s2_reg <= '0;
    end else if (clr) begin
      ctl_s2_reg <= '0;
    end else begin
      ctl_s2_reg <= ctl_s1_reg;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [SUM_W-1:0] prod_ext [LANES];
  logic [SUM_W-1:0] lane_sum;

  // Each product is widened to the lane-sum width according to the beat's
  // signedness; the sum then behaves as a signed quantity in both modes.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_ext
      assign prod_ext[gi] = {{(SUM_W-PW){ctl_s2_reg.sgn & prod_s2[gi][PW-1]}},
                             prod_s2[gi]};
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + prod_ext[i];
    end
  end

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic [ACC_W-1:0] cout_reg;
  logic             cout_vld_reg;
  logic             ovf_reg;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   total;
  logic             beat_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W:0]   cnt_inc;
  logic             vec_done;

  // The accumulator is read with the current beat's signedness and summed in
  // ACC_W+1 bits. Unsigned: a carry into bit ACC_W is an overflow. Signed:
  // the top two bits disagreeing is an overflow, and bit ACC_W gives its
  // direction.
  always_comb begin
    sum_ext  = {{(ACC_W+1-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
    acc_ext  = {ctl_s2_reg.sgn & acc_reg[ACC_W-1], acc_reg};
    total    = acc_ext + sum_ext;
    beat_ovf = ctl_s2_reg.sgn ? (total[ACC_W] ^ total[ACC_W-1]) : total[ACC_W];

    acc_next = total[ACC_W-1:0];
    if (beat_ovf && sat_en) begin
      if (!ctl_s2_reg.sgn) begin
        acc_next = UMAX;
      end else if (total[ACC_W]) begin
        acc_next = SMIN;
      end else begin
        acc_next = SMAX;
      end
    end

    // ">=" rather than "==" so a vector whose len was lowered below the
    // current count still terminates on its next beat.
    cnt_inc  = {1'b0, count_reg} + {{CNT_W{1'b0}}, 1'b1};
    vec_done = (len != '0) && (cnt_inc >= {1'b0, len});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      count_reg    <= '0;
      cout_reg     <= '0;
      cout_vld_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (clr) begin
      acc_reg      <= '0;
      count_reg    <= '0;
      cout_reg     <= '0;
      cout_vld_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      cout_vld_reg <= 1'b0;
      if (ctl_s2_reg.vld) begin
        ovf_reg <= ovf_reg | beat_ovf;
        if (len == '0) begin
          // Free-running: publish every beat, never auto-clear.
          acc_reg      <= acc_next;
          cout_reg     <= acc_next;
          cout_vld_reg <= 1'b1;
          count_reg    <= cnt_inc[CNT_W-1:0];
        end else if (vec_done) begin
          cout_reg     <= acc_next;
          cout_vld_reg <= 1'b1;
          acc_reg      <= '0;
          count_reg    <= '0;
        end else begin
          acc_reg      <= acc_next;
          count_reg    <= cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

  assign cout     = cout_reg;
  assign cout_vld = cout_vld_reg;
  assign ovf      = ovf_reg;

endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 Parameter DATA_W, default 8, operand width per lane.
REQ-002 Parameter LANES, default 4, number of parallel multiplier lanes summed per beat.
REQ-003 Parameter ACC_W, default 24, accumulator and result width; SHALL be >= 2*DATA_W+$clog2(LANES)+1.
REQ-004 Parameter CNT_W, default 8, vector-length counter width.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  beat valid; a/b/sgn sampled when high.
REQ-008 clr  input  1  synchronous clear of accumulator, pipeline, counter, flags.
REQ-009 sgn  input  1  1 = two's-complement operands, 0 = unsigned; travels with the beat.
REQ-010 sat_en  input  1  1 = saturate on overflow, 0 = wrap; applied at accumulate stage.
REQ-011 len  input  CNT_W  beats per vector; 0 = free-running; quasi-static within a vector.
REQ-012 a  input  LANES*DATA_W  lane operands, lane 0 in LSBs.
REQ-013 b  input  LANES*DATA_W  lane operands, lane 0 in LSBs.
REQ-014 cout  output  ACC_W  vector result, registered.
REQ-015 cout_vld  output  1  one-cycle pulse when cout is updated.
REQ-016 ovf  output  1  sticky overflow flag.

Function
REQ-017 Pipeline: S1 registers a, b, sgn, valid; S2 registers the LANES products; S3 sums the products, accumulates, and updates cout; an en beat at edge N SHALL update cout/cout_vld at edge N+3.
REQ-018 Product width is 2*DATA_W, signed or unsigned per the beat's sgn; the lane sum is sign- or zero-extended to ACC_W+1 before accumulation.
REQ-019 Bubbles (en=0) SHALL propagate as invalid and change neither accumulator nor counter.
REQ-020 Beat counter increments per valid S3 beat; when len!=0 and count==len-1, S3 SHALL load cout with acc+sum, pulse cout_vld, and reset acc and count to 0 on the same edge.
REQ-021 With len==0, every valid S3 beat SHALL update acc and cout and pulse cout_vld; acc is never auto-cleared.
REQ-022 Overflow is detected on the ACC_W+1 sum against ACC_W range for the beat's sgn; on overflow, ovf SHALL be set and stay set until clr or reset.
REQ-023 On overflow with sat_en=1, acc/cout clamp to max (unsigned 2^ACC_W-1; signed 2^(ACC_W-1)-1) or signed min (-2^(ACC_W-1)); with sat_en=0, they wrap modulo 2^ACC_W.
REQ-024 Between vectors, cout SHALL hold its last value.
REQ-025 clr has priority over en: it zeroes acc, cout, count, and ovf, invalidates S1-S3 in-flight beats (discarded, no cout_vld), and an en beat in the clr cycle is dropped.
REQ-026 Changing len mid-vector is unsupported; if len<=count, the next valid beat SHALL complete the vector.

Reset
REQ-027 On rst_n low: cout=0, cout_vld=0, ovf=0, acc=0, count=0, all pipeline valid bits 0, immediately and asynchronously.
REQ-028 Reset mid-vector SHALL discard all partial state; the first en beat after release starts a new vector.

Structure
REQ-029 Package mac_pkg SHALL hold the default parameter constants and the saturation-limit and sum-width helper functions.
REQ-030 Sub-module mac_lane_mult: one DATA_W x DATA_W signed/unsigned multiplier with registered product (S2), instantiated LANES times.

Verification (DATA_W=8, LANES=4, ACC_W=24)
REQ-031 sgn=0, len=2, all lanes a=b=255, two consecutive beats -> single cout_vld 3 cycles after beat 2, cout=520200 (0x07F008), ovf=0.
REQ-032 sgn=1, len=1, all lanes a=-128, b=127, one beat -> cout=0xFF0200 (-65024), cout_vld one pulse.
REQ-033 sgn=0, len=0, a=b=255 all lanes, 65 beats; sat_en=1 -> cout=0xFFFFFF, ovf=1; sat_en=0 -> cout=0x01F904, ovf=1.
REQ-034 len=3 with beats separated by en=0 gaps -> exactly one cout_vld after the third valid beat; bubbles are not counted.
REQ-035 Two beats in flight, clr asserted -> no cout_vld, cout=0, ovf=0; the next vector's result excludes the discarded beats.
REQ-036 rst_n pulsed mid-vector (len=4, two beats accepted) -> all outputs 0 asynchronously; a fresh 4-beat vector after release yields the correct sum.
